// File: rtl/ni_out_buffer_mc.sv
// Multi-channel credit-based NI output buffer. It keeps one flit FIFO and one
// credit counter per virtual channel. A round-robin arbiter, with optional
// per-packet locking, drives one registered NoC link.
module ni_out_buffer_mc #(
    parameter int FLIT_WIDTH  = 80,
    parameter int NUM_CH      = 2,
    parameter int LOG_NUM_CH  = 1,
    parameter int DEPTH       = 4,
    parameter int LOG_DEPTH   = 2,
    parameter int CREDITS     = 4,
    parameter int LOG_CREDITS = 3,
    parameter int TAIL_BIT    = 0,
    parameter int PKT_LOCK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic [LOG_NUM_CH-1:0] ch_in,
    output logic [NUM_CH-1:0]     full,
    output logic [FLIT_WIDTH-1:0] FLIT_out,
    output logic                  VALID_out,
    output logic [LOG_NUM_CH-1:0] CH_out,
    input  logic [NUM_CH-1:0]     CREDIT_in,
    output logic                  credit_err
);

    localparam logic [LOG_DEPTH:0]     DEPTH_C   = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH-1:0]   LAST_SLOT = LOG_DEPTH'(DEPTH-1);
    localparam logic [LOG_CREDITS-1:0] CREDITS_C = LOG_CREDITS'(CREDITS);
    localparam logic [LOG_NUM_CH-1:0]  LAST_CH   = LOG_NUM_CH'(NUM_CH-1);

    logic [FLIT_WIDTH-1:0]  mem     [NUM_CH][DEPTH];
    logic [LOG_DEPTH-1:0]   wr_ptr  [NUM_CH];
    logic [LOG_DEPTH-1:0]   rd_ptr  [NUM_CH];
    logic [LOG_DEPTH:0]     count   [NUM_CH];
    logic [LOG_CREDITS-1:0] credits [NUM_CH];

    logic [LOG_NUM_CH-1:0]  rr_ptr;
    logic [LOG_NUM_CH-1:0]  lock_ch;
    logic                   locked;

    logic [NUM_CH-1:0]      wr_en;
    logic [NUM_CH-1:0]      eligible;
    logic [NUM_CH-1:0]      pop;
    logic                   gnt_vld_p0;
    logic [LOG_NUM_CH-1:0]  gnt_ch_p0;
    logic [FLIT_WIDTH-1:0]  head_p0;

    // Advance a FIFO pointer, wrapping at DEPTH-1 so that non-power-of-2 depths work.
    function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
        if (p == LAST_SLOT)
            return '0;
        return p + 1'b1;
    endfunction

    // Per-channel status: full flag, write acceptance and arbitration eligibility.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full[c]     = (count[c] == DEPTH_C);
            wr_en[c]    = write && (ch_in == LOG_NUM_CH'(c)) && (count[c] != DEPTH_C);
            eligible[c] = (count[c] != '0) && (credits[c] != '0) &&
                          ((PKT_LOCK == 0) || !locked || (lock_ch == LOG_NUM_CH'(c)));
        end
    end

    // Round-robin grant: search starts one past the last granted channel.
    always_comb begin
        int idx;
        idx        = 0;
        gnt_vld_p0 = 1'b0;
        gnt_ch_p0  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH)
                idx = idx - NUM_CH;
            if (!gnt_vld_p0 && eligible[idx]) begin
                gnt_vld_p0 = 1'b1;
                gnt_ch_p0  = LOG_NUM_CH'(idx);
            end
        end
    end

    // Head flit of the granted channel and the per-channel pop strobes.
    always_comb begin
        head_p0 = mem[gnt_ch_p0][rd_ptr[gnt_ch_p0]];
        for (int c = 0; c < NUM_CH; c++)
            pop[c] = gnt_vld_p0 && (gnt_ch_p0 == LOG_NUM_CH'(c));
    end

    // FIFO storage. Data is not reset; the pointers and counts decide what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (wr_en[c])
                mem[c][wr_ptr[c]] <= data_in;
    end

    // FIFO pointers and occupancy. A write and a pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en[c])
                    wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                if (pop[c])
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                case ({wr_en[c], pop[c]})
                    2'b10:   count[c] <= count[c] + 1'b1;
                    2'b01:   count[c] <= count[c] - 1'b1;
                    default: count[c] <= count[c];
                endcase
            end
        end
    end

    // Credit counters: -1 per sent flit, +1 per returned credit, saturating with a sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++)
                credits[c] <= CREDITS_C;
            credit_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ({pop[c], CREDIT_in[c]})
                    2'b10: credits[c] <= credits[c] - 1'b1;
                    2'b01: begin
                        if (credits[c] == CREDITS_C)
                            credit_err <= 1'b1;
                        else
                            credits[c] <= credits[c] + 1'b1;
                    end
                    default: credits[c] <= credits[c];
                endcase
            end
        end
    end

    // ---- stage boundary: arbitration result registered onto the link ----
    // Link output register plus the round-robin pointer and packet lock state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr    <= LAST_CH;
            locked    <= 1'b0;
            lock_ch   <= '0;
            VALID_out <= 1'b0;
            FLIT_out  <= '0;
            CH_out    <= '0;
        end else begin
            VALID_out <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                FLIT_out <= head_p0;
                CH_out   <= gnt_ch_p0;
                rr_ptr   <= gnt_ch_p0;
                if (PKT_LOCK != 0) begin
                    locked  <= !head_p0[TAIL_BIT];
                    lock_ch <= gnt_ch_p0;
                end
            end
        end
    end

endmodule
